str_to_int_stream: RTL and testbench

STR_TO_INT_STREAM -- requirements
Module: str_to_int_stream

---
 rtl/str_parse_pkg.sv | 18 +
 rtl/ascii_char_class.sv | 21 ++
 rtl/str_to_int_stream.sv | 142 ++++++++++++++
 tb/tb_str_to_int_stream.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/str_parse_pkg.sv
// Shared definitions for the decimal string parser: FSM states and the
// ASCII constants that steer it.
package str_parse_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DIGITS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_SP    = 8'h20;
   localparam logic [7:0] CH_MINUS = 8'h2D;
   localparam logic [7:0] CH_PLUS  = 8'h2B;
   localparam logic [7:0] CH_ZERO  = 8'h30;

endpackage

// File: rtl/ascii_char_class.sv
// Combinational classifier for one ASCII character: digit, sign or
// terminator, plus the binary value of a digit.
module ascii_char_class
   import str_parse_pkg::*;
(
   input  logic [7:0] i_char,
   output logic       o_is_digit,
   output logic [3:0] o_digit,
   output logic       o_is_sign,
   output logic       o_is_minus,
   output logic       o_is_term
);

   assign o_is_digit = (i_char >= CH_ZERO) && (i_char <= (CH_ZERO + 8'd9));
   // '0'..'9' are 0x30..0x39, so the low nibble is already the digit value.
   assign o_digit    = i_char[3:0];
   assign o_is_minus = (i_char == CH_MINUS);
   assign o_is_sign  = o_is_minus || (i_char == CH_PLUS);
   assign o_is_term  = (i_char == CH_CR) || (i_char == CH_LF) || (i_char == CH_SP);

endmodule

// File: rtl/str_to_int_stream.sv
// Streaming ASCII decimal to two's-complement integer converter with
// valid/ready handshakes on both the character and the result side.
module str_to_int_stream
   import str_parse_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int MAX_DIGITS = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [7:0]       in_char,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_value,
   output logic             out_error,
   input  logic             out_ready
);

   localparam int ACC_W = WIDTH + 4;
   localparam int CNT_W = $clog2(MAX_DIGITS + 1);
   localparam logic [ACC_W-1:0] NEG_LIMIT = ACC_W'(1) << (WIDTH - 1);
   localparam logic [ACC_W-1:0] POS_LIMIT = NEG_LIMIT - ACC_W'(1);

   state_t             r_state, w_state_nxt;
   logic [ACC_W-1:0]   r_mag, w_mag_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic               r_neg, w_neg_nxt;
   logic               r_err, w_err_nxt;
   logic [WIDTH-1:0]   r_out_value, w_out_value_nxt;
   logic               r_out_error, w_out_error_nxt;
   logic               r_live;

   logic               w_is_digit, w_is_sign, w_is_minus, w_is_term;
   logic [3:0]         w_digit;
   logic               w_take;
   logic [ACC_W-1:0]   w_limit, w_mac;
   logic [WIDTH-1:0]   w_mag_lo;
   logic               w_term_err;

   ascii_char_class u_class (
      .i_char     (in_char),
      .o_is_digit (w_is_digit),
      .o_digit    (w_digit),
      .o_is_sign  (w_is_sign),
      .o_is_minus (w_is_minus),
      .o_is_term  (w_is_term)
   );

   // in_ready stays low until the first edge after reset release.
   assign in_ready  = r_live && (r_state != ST_DONE);
   assign out_valid = (r_state == ST_DONE);
   assign out_value = r_out_value;
   assign out_error = r_out_error;

   assign w_take     = in_valid && in_ready;
   assign w_limit    = r_neg ? NEG_LIMIT : POS_LIMIT;
   assign w_mac      = (r_mag * ACC_W'(10)) + ACC_W'(w_digit);
   assign w_mag_lo   = r_mag[WIDTH-1:0];
   assign w_term_err = r_err || (r_cnt == '0);

   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a signal unassigned, which would infer a latch.
      w_state_nxt     = r_state;
      w_mag_nxt       = r_mag;
      w_cnt_nxt       = r_cnt;
      w_neg_nxt       = r_neg;
      w_err_nxt       = r_err;
      w_out_value_nxt = r_out_value;
      w_out_error_nxt = r_out_error;

      case (r_state)
         ST_IDLE, ST_DIGITS: begin
            if (w_take) begin
               if (w_is_term) begin
                  if (r_state == ST_DIGITS) begin
                     w_state_nxt     = ST_DONE;
                     w_out_error_nxt = w_term_err;
                     w_out_value_nxt = w_term_err ? '0 : (r_neg ? -w_mag_lo : w_mag_lo);
                  end
               end else if (w_is_digit) begin
                  w_state_nxt = ST_DIGITS;
                  if (r_cnt < CNT_W'(MAX_DIGITS)) begin
                     w_cnt_nxt = r_cnt + 1'b1;
                  end else begin
                     w_err_nxt = 1'b1;
                  end
                  // Saturate at the limit so the accumulator can never wrap.
                  if (w_mac > w_limit) begin
                     w_mag_nxt = w_limit;
                     w_err_nxt = 1'b1;
                  end else begin
                     w_mag_nxt = w_mac;
                  end
               end else if (w_is_sign && (r_state == ST_IDLE)) begin
                  w_state_nxt = ST_DIGITS;
                  w_neg_nxt   = w_is_minus;
               end else begin
                  w_state_nxt = ST_DIGITS;
                  w_err_nxt   = 1'b1;
               end
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               w_state_nxt = ST_IDLE;
               w_mag_nxt   = '0;
               w_cnt_nxt   = '0;
               w_neg_nxt   = 1'b0;
               w_err_nxt   = 1'b0;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_mag       <= '0;
         r_cnt       <= '0;
         r_neg       <= 1'b0;
         r_err       <= 1'b0;
         r_out_value <= '0;
         r_out_error <= 1'b0;
         r_live      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_mag       <= w_mag_nxt;
         r_cnt       <= w_cnt_nxt;
         r_neg       <= w_neg_nxt;
         r_err       <= w_err_nxt;
         r_out_value <= w_out_value_nxt;
         r_out_error <= w_out_error_nxt;
         r_live      <= 1'b1;
      end
   end

endmodule

// File: tb/tb_str_to_int_stream.sv
// Self-checking bench for str_to_int_stream: token-level reference model,
// per-cycle output comparison, directed corner cases and random streams.
module tb_str_to_int_stream;

   localparam int WIDTH      = 16;
   localparam int MAX_DIGITS = 5;

   typedef struct {
      logic [WIDTH-1:0] val;
      logic             err;
   } res_t;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic [7:0]       in_char;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_value;
   logic             out_error;
   logic             out_ready;

   int n_checks = 0;
   int n_err    = 0;

   logic [7:0] tok[$];
   res_t       exp_q[$];
   res_t       got_q[$];
   bit         pend = 0;
   bit         live;
   bit         ready_force = 1;
   bit         ready_val   = 1;

   str_to_int_stream #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_char   (in_char),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_value (out_value),
      .out_error (out_error),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic bit is_term(input logic [7:0] c);
      return (c == 8'h0D) || (c == 8'h0A) || (c == 8'h20);
   endfunction

   // Reference: evaluate a whole token by the textual rules.
   function automatic res_t model_eval();
      res_t   r;
      bit     neg = 0;
      bit     err = 0;
      int     nd  = 0;
      int     k0  = 0;
      longint mag = 0;
      longint v;
      if (tok[0] == 8'h2D || tok[0] == 8'h2B) begin
         neg = (tok[0] == 8'h2D);
         k0  = 1;
      end
      for (int k = k0; k < tok.size(); k++) begin
         if (tok[k] >= 8'h30 && tok[k] <= 8'h39) begin
            nd++;
            mag = mag * 10 + longint'(tok[k] - 8'h30);
            if (mag > 64'd100000000) mag = 100000000;
         end else begin
            err = 1;
         end
      end
      if (nd == 0 || nd > MAX_DIGITS) err = 1;
      if (mag > (neg ? (longint'(1) << (WIDTH-1)) : ((longint'(1) << (WIDTH-1)) - 1))) err = 1;
      v     = neg ? -mag : mag;
      r.err = err;
      r.val = err ? '0 : v[WIDTH-1:0];
      return r;
   endfunction

   task automatic model_char(input logic [7:0] c);
      if (is_term(c)) begin
         if (tok.size() > 0) begin
            exp_q.push_back(model_eval());
            tok.delete();
            pend = 1;
         end
      end else begin
         tok.push_back(c);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) live <= 1'b0;
      else        live <= 1'b1;
   end

   // Compare process: outputs are sampled on the falling edge.
   always @(negedge clk) begin
      res_t g;
      if (!rst_n) begin
         tok.delete();
         exp_q.delete();
         pend = 0;
      end else begin
         if (pend) begin
            check("latency_out_valid", 32'(out_valid), 32'd1);
            pend = 0;
         end
         if (live) check("in_ready_vs_out_valid", 32'(in_ready), 32'(!out_valid));
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL unexpected_result: got value 0x%0h error %0b with no token pending", out_value, out_error);
            end else begin
               check("out_value", 32'(out_value), 32'(exp_q[0].val));
               check("out_error", 32'(out_error), 32'(exp_q[0].err));
               if (out_ready) begin
                  g.val = out_value;
                  g.err = out_error;
                  got_q.push_back(g);
                  void'(exp_q.pop_front());
               end
            end
         end
         if (in_valid && in_ready) model_char(in_char);
      end
   end

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = ready_force ? ready_val : ($urandom_range(0, 3) != 0);
      end
   end

   task automatic send_char(input logic [7:0] c, input bit gaps);
      int guard = 0;
      if (gaps && $urandom_range(0, 3) == 0) begin
         repeat ($urandom_range(1, 2)) begin
            @(posedge clk);
            #1;
         end
      end
      in_valid = 1'b1;
      in_char  = c;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         guard++;
         if (guard > 500) begin
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", guard);
            $fatal(1, "send timeout");
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_str(input string s, input logic [7:0] term);
      for (int i = 0; i < s.len(); i++) send_char(s[i], 1'b0);
      if (term != 8'h00) send_char(term, 1'b0);
   endtask

   task automatic expect_result(input string name, input logic [WIDTH-1:0] val, input logic err);
      res_t g;
      for (int k = 0; k < 300 && got_q.size() == 0; k++) begin
         @(negedge clk);
         #1;
      end
      if (got_q.size() == 0) begin
         n_checks++;
         n_err++;
         $display("FAIL %s: no result within 300 cycles, required value 0x%0h", name, val);
      end else begin
         g = got_q.pop_front();
         check({name, "_value"}, 32'(g.val), 32'(val));
         check({name, "_error"}, 32'(g.err), 32'(err));
      end
   endtask

   initial begin
      string      ex[4];
      logic [7:0] rq[$];
      logic [7:0] terms[3];
      int         kind, nd, guard;

      ex[0] = "32767"; ex[1] = "-32768"; ex[2] = "32768"; ex[3] = "-32769";
      terms[0] = 8'h0D; terms[1] = 8'h0A; terms[2] = 8'h20;

      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_char  = 8'h00;
      #2;
      check("rst_in_ready",  32'(in_ready),  32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_value", 32'(out_value), 32'd0);
      check("rst_out_error", 32'(out_error), 32'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      #1 check("in_ready_before_first_edge", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1 check("in_ready_after_first_edge", 32'(in_ready), 32'd1);

      send_str("1234", 8'h0D);   expect_result("d_1234", 16'd1234, 1'b0);
      send_str("-32768", 8'h20); expect_result("d_min", 16'h8000, 1'b0);
      send_str("32768", 8'h20);  expect_result("d_over", 16'd0, 1'b1);
      send_str("12a4", 8'h0A);   expect_result("d_bad_char", 16'd0, 1'b1);
      send_str("-", 8'h0A);      expect_result("d_sign_only", 16'd0, 1'b1);
      send_str("123456", 8'h0A); expect_result("d_too_many", 16'd0, 1'b1);
      send_str("  +0042", 8'h0D); expect_result("d_lead_sp", 16'd42, 1'b0);
      send_str("-0", 8'h20);     expect_result("d_neg_zero", 16'd0, 1'b0);

      // Hold the consumer off for five cycles.
      ready_val = 1'b0;
      send_str("7", 8'h0D);
      guard = 0;
      while (!out_valid && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_out_valid", 32'(out_valid), 32'd1);
         check("hold_out_value", 32'(out_value), 32'd7);
         check("hold_in_ready",  32'(in_ready),  32'd0);
      end
      ready_val = 1'b1;
      expect_result("d_held", 16'd7, 1'b0);
      @(negedge clk);
      check("post_hs_in_ready",  32'(in_ready),  32'd1);
      check("post_hs_out_valid", 32'(out_valid), 32'd0);
      check("post_hs_single",    32'(got_q.size()), 32'd0);

      // Asynchronous reset in the middle of a number.
      send_str("98", 8'h00);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("mid_rst_in_ready",  32'(in_ready),  32'd0);
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_out_value", 32'(out_value), 32'd0);
      check("mid_rst_out_error", 32'(out_error), 32'd0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      #1 check("rel_in_ready_low", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1 check("rel_in_ready_high", 32'(in_ready), 32'd1);
      send_str("5", 8'h0D);
      expect_result("d_after_rst", 16'd5, 1'b0);

      // Random token stream, checked by the compare process.
      ready_force = 1'b0;
      for (int t = 0; t < 80; t++) begin
         rq.delete();
         if ($urandom_range(0, 4) == 0) rq.push_back(8'h20);
         kind = $urandom_range(0, 9);
         case (kind)
            5: begin
               string s;
               s = ex[$urandom_range(0, 3)];
               for (int i = 0; i < s.len(); i++) rq.push_back(s[i]);
            end
            6: begin
               nd = $urandom_range(1, 4);
               for (int i = 0; i < nd; i++) rq.push_back(8'(8'h30 + $urandom_range(0, 9)));
               rq.push_back($urandom_range(0, 1) ? 8'(8'h61 + $urandom_range(0, 25)) : 8'h2B);
               rq.push_back(8'h31);
            end
            7: begin
               rq.push_back($urandom_range(0, 1) ? 8'h2D : 8'h2B);
               if ($urandom_range(0, 1)) begin
                  rq.push_back(8'h2D);
                  rq.push_back(8'h33);
               end
            end
            8: begin
               nd = $urandom_range(1, 4);
               repeat ($urandom_range(1, 3)) rq.push_back(8'h30);
               for (int i = 0; i < nd; i++) rq.push_back(8'(8'h30 + $urandom_range(0, 9)));
            end
            9: begin
               if ($urandom_range(0, 1)) rq.push_back(8'h2D);
               rq.push_back(8'(8'h33 + $urandom_range(0, 6)));
               for (int i = 0; i < 4; i++) rq.push_back(8'(8'h30 + $urandom_range(0, 9)));
            end
            default: begin
               if ($urandom_range(0, 2) == 0) rq.push_back($urandom_range(0, 1) ? 8'h2D : 8'h2B);
               nd = $urandom_range(1, 6);
               for (int i = 0; i < nd; i++) rq.push_back(8'(8'h30 + $urandom_range(0, 9)));
            end
         endcase
         rq.push_back(terms[$urandom_range(0, 2)]);
         foreach (rq[i]) send_char(rq[i], 1'b1);
      end

      guard = 0;
      while ((exp_q.size() != 0 || out_valid) && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      check("drain_pending", 32'(exp_q.size()), 32'd0);
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
